shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer_pkg.sv | 21 ++
 rtl/shift_sequencer_step.sv | 52 +++++
 rtl/shift_sequencer.sv | 169 ++++++++++++++++
 tb/tb_shift_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the iterative operand-2 shifter: shift-kind
// encodings and the sequencer state encoding.
package shift_sequencer_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Width needed to hold a per-step amount in the range 0..step.
    function automatic int step_amt_width(input int step);
        return $clog2(step + 1);
    endfunction

endpackage

// File: rtl/shift_sequencer_step.sv
// Combinational narrow shifter: moves a value by 0..STEP bits in one of the
// four ARM shift kinds and reports the last bit shifted out. An amount of 0
// returns the value unchanged with carry 0 (the sequencer never uses it).
module shift_step
    import shift_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 4,
    localparam int AMT_W = step_amt_width(STEP)
) (
    input  logic [DATA_W-1:0] value,
    input  logic [1:0]        kind,
    input  logic [AMT_W-1:0]  amount,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W-1:0] probe;

    // Shift by the requested amount; probe is the value moved by one bit
    // less, so its edge bit is the last bit to leave the word.
    always_comb begin
        result = value;
        carry  = 1'b0;
        probe  = value;
        if (amount != '0) begin
            case (kind)
                SH_LSL: begin
                    result = value << amount;
                    probe  = value << (amount - 1'b1);
                    carry  = probe[DATA_W-1];
                end
                SH_LSR: begin
                    result = value >> amount;
                    probe  = value >> (amount - 1'b1);
                    carry  = probe[0];
                end
                SH_ASR: begin
                    result = $unsigned($signed(value) >>> amount);
                    probe  = value >> (amount - 1'b1);
                    carry  = probe[0];
                end
                default: begin
                    result = (value >> amount) | (value << (DATA_W - int'(amount)));
                    probe  = value >> (amount - 1'b1);
                    carry  = probe[0];
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative operand-2 shifter: accepts one request over valid/ready, shifts
// up to STEP bits per clock through a single shift_step, then holds the
// result and ARM carry-out until consumed. flush aborts synchronously.
// Optional build macro SHIFT_SEQ_PERF_EN adds perf_ops / perf_shift_cycles.
//
// state    | meaning
// ST_IDLE  | ready for a request; accept edge applies the first step
// ST_SHIFT | applying min(STEP, remaining) bits per clock
// ST_DONE  | result valid, held until out_ready
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_val,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_amt,
    input  logic              in_carry,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_carry,
    output logic              busy
`ifdef SHIFT_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_shift_cycles
`endif
);

    localparam int         AMT_W    = step_amt_width(STEP);
    localparam logic [4:0] STEP_AMT = 5'(STEP);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              carry_q, carry_d;
    logic [1:0]        kind_q, kind_d;
    logic [4:0]        rem_q, rem_d;

    logic [DATA_W-1:0] step_src;
    logic [1:0]        step_kind;
    logic [4:0]        rem_src;
    logic [4:0]        step_full;
    logic [AMT_W-1:0]  step_amt;
    logic [DATA_W-1:0] step_res;
    logic              step_carry;

    // The one shift resource sees the incoming request while idle (so the
    // accept edge does useful work) and the working register afterwards.
    always_comb begin
        step_src  = data_q;
        step_kind = kind_q;
        rem_src   = rem_q;
        if (state_q == ST_IDLE) begin
            step_src  = in_val;
            step_kind = in_kind;
            rem_src   = in_amt;
        end
        step_full = (rem_src > STEP_AMT) ? STEP_AMT : rem_src;
        step_amt  = step_full[AMT_W-1:0];
    end

    shift_step #(
        .DATA_W (DATA_W),
        .STEP   (STEP)
    ) u_step (
        .value  (step_src),
        .kind   (step_kind),
        .amount (step_amt),
        .result (step_res),
        .carry  (step_carry)
    );

    // Next-state and handshake decode; flush overrides everything.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        carry_d   = carry_q;
        kind_d    = kind_q;
        rem_d     = rem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    kind_d = in_kind;
                    if (in_amt == 5'd0) begin
                        data_d  = in_val;
                        carry_d = in_carry;
                        rem_d   = 5'd0;
                        state_d = ST_DONE;
                    end else begin
                        data_d  = step_res;
                        carry_d = step_carry;
                        rem_d   = in_amt - step_full;
                        state_d = (rem_d == 5'd0) ? ST_DONE : ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                data_d  = step_res;
                carry_d = step_carry;
                rem_d   = rem_q - step_full;
                if (rem_d == 5'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            carry_q <= 1'b0;
            kind_q  <= SH_LSL;
            rem_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            kind_q  <= kind_d;
            rem_q   <= rem_d;
        end
    end

    assign out_data  = data_q;
    assign out_carry = carry_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef SHIFT_SEQ_PERF_EN
    // Count delivered results (a flush in DONE drops the result) and
    // every clock spent iterating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_ops          <= 32'd0;
            perf_shift_cycles <= 32'd0;
        end else begin
            if (state_q == ST_DONE && out_ready && !flush) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (state_q == ST_SHIFT) begin
                perf_shift_cycles <= perf_shift_cycles + 32'd1;
            end
        end
    end
`else
    // Core-only build: no performance counters.
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer (STEP=4): table of directed
// vectors, random requests against a full-width reference model, and
// hand-written flush / reset / backpressure sequences.
module tb_shift_sequencer;

    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_val = '0;
    logic [1:0]  in_kind = 2'b00;
    logic [4:0]  in_amt = '0;
    logic        in_carry = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_carry;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] val;
        logic [1:0]  kind;
        logic [4:0]  amt;
        logic        cin;
        logic [31:0] exp_data;
        logic        exp_carry;
        int          exp_lat;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        carry;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];

    shift_sequencer #(.DATA_W(32), .STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_val    (in_val),
        .in_kind   (in_kind),
        .in_amt    (in_amt),
        .in_carry  (in_carry),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Whole-word reference: shift by the total amount at once.
    function automatic exp_t model(input logic [31:0] v, input logic [1:0] k,
                                   input logic [4:0] a, input logic c);
        exp_t e;
        int n;
        n = int'(a);
        e.lat = (n == 0) ? 1 : (n + STEP - 1) / STEP;
        if (n == 0) begin
            e.data  = v;
            e.carry = c;
        end else begin
            case (k)
                2'b00: begin e.data = v << n; e.carry = v[32-n]; end
                2'b01: begin e.data = v >> n; e.carry = v[n-1]; end
                2'b10: begin e.data = $unsigned($signed(v) >>> n); e.carry = v[n-1]; end
                default: begin e.data = (v >> n) | (v << (32 - n)); e.carry = v[n-1]; end
            endcase
        end
        return e;
    endfunction

    task automatic run_req(input logic [31:0] v, input logic [1:0] k, input logic [4:0] a,
                           input logic c, input logic [31:0] ed, input logic ec,
                           input int el, input int hold);
        exp_t e;
        int edges;
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_val   = v;
        in_kind  = k;
        in_amt   = a;
        in_carry = c;
        e.data = ed;
        e.carry = ec;
        e.lat = el;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 64) begin
            check("busy_in_shift", {31'd0, busy}, 32'd1);
            check("in_ready_in_shift", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            edges++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        check("latency", edges, e.lat);
        check("out_data", out_data, e.data);
        check("out_carry", {31'd0, out_carry}, {31'd0, e.carry});
        check("busy_in_done", {31'd0, busy}, 32'd1);
        if (hold > 0) begin
            in_valid = 1'b1;
            in_val   = 32'hDEAD_BEEF;
            in_kind  = 2'b00;
            in_amt   = 5'd1;
            repeat (hold) begin
                @(posedge clk);
                #1;
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", out_data, e.data);
                check("hold_carry", {31'd0, out_carry}, {31'd0, e.carry});
                check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic watch_no_output(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        exp_t m;
        //          val           kind   amt   cin   exp_data      c     L  hold
        vecs[0]  = '{32'h0000_0001, 2'b00, 5'd4,  1'b0, 32'h0000_0010, 1'b0, 1, 0};
        vecs[1]  = '{32'h8000_0000, 2'b10, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b0, 8, 0};
        vecs[2]  = '{32'h0000_00FF, 2'b11, 5'd8,  1'b0, 32'hFF00_0000, 1'b1, 2, 0};
        vecs[3]  = '{32'h0000_0003, 2'b01, 5'd1,  1'b0, 32'h0000_0001, 1'b1, 1, 0};
        vecs[4]  = '{32'h1234_5678, 2'b00, 5'd0,  1'b1, 32'h1234_5678, 1'b1, 1, 0};
        vecs[5]  = '{32'h8000_0001, 2'b00, 5'd1,  1'b0, 32'h0000_0002, 1'b1, 1, 5};
        vecs[6]  = '{32'hF000_0000, 2'b01, 5'd5,  1'b1, 32'h0780_0000, 1'b0, 2, 0};
        vecs[7]  = '{32'h7FFF_FFF0, 2'b10, 5'd4,  1'b1, 32'h07FF_FFFF, 1'b0, 1, 0};
        vecs[8]  = '{32'h0000_0001, 2'b11, 5'd31, 1'b0, 32'h0000_0002, 1'b0, 8, 0};
        vecs[9]  = '{32'hFFFF_FFFF, 2'b00, 5'd31, 1'b0, 32'h8000_0000, 1'b1, 8, 2};
        vecs[10] = '{32'h8000_0000, 2'b10, 5'd0,  1'b0, 32'h8000_0000, 1'b0, 1, 0};
        vecs[11] = '{32'h8000_0000, 2'b01, 5'd9,  1'b1, 32'h0040_0000, 1'b0, 3, 0};

        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_carry", {31'd0, out_carry}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i].val, vecs[i].kind, vecs[i].amt, vecs[i].cin,
                    vecs[i].exp_data, vecs[i].exp_carry, vecs[i].exp_lat, vecs[i].hold);
        end

        // flush mid-SHIFT of a 31-bit shift: no result, back to idle
        @(negedge clk);
        in_valid = 1'b1; in_val = 32'h8000_0000; in_kind = 2'b10; in_amt = 5'd31;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        watch_no_output("flush_no_result", 12);
        run_req(32'h0000_0001, 2'b00, 5'd1, 1'b0, 32'h0000_0002, 1'b0, 1, 0);

        // flush in IDLE with in_valid high must not accept
        @(negedge clk);
        in_valid = 1'b1; in_val = 32'h0000_0001; in_kind = 2'b00; in_amt = 5'd8;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_idle_busy", {31'd0, busy}, 32'd0);
        watch_no_output("flush_idle_no_result", 4);

        // asynchronous reset mid-SHIFT
        @(negedge clk);
        in_valid = 1'b1; in_val = 32'hFFFF_0000; in_kind = 2'b01; in_amt = 5'd31;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        watch_no_output("arst_no_result", 12);
        run_req(32'h0000_0001, 2'b00, 5'd1, 1'b0, 32'h0000_0002, 1'b0, 1, 0);

        // random requests against the reference model
        for (int i = 0; i < 20; i++) begin
            logic [31:0] rv;
            logic [1:0]  rk;
            logic [4:0]  ra;
            logic        rc;
            rv = $urandom;
            rk = 2'($urandom_range(0, 3));
            ra = 5'($urandom_range(0, 31));
            rc = 1'($urandom_range(0, 1));
            m = model(rv, rk, ra, rc);
            run_req(rv, rk, ra, rc, m.data, m.carry, m.lat, int'($urandom_range(0, 2)));
        end

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
